// File: rtl/dual_lane_deinterleaver.sv
// Re-pairs serially delivered lane-0/lane-1 MAC results into one parallel word per pair,
// with valid/ready on both sides, a sticky lane-sequence error flag and a delivered-pair counter.
module dual_lane_deinterleaver #(
    parameter int W  = 17,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    input  logic          s_lane,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  dout0,
    output logic [W-1:0]  dout1,
    output logic          err_seq,
    input  logic          clr_err,
    output logic [CW-1:0] pair_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT0 = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [W-1:0]  hold0_r;
    logic [W-1:0]  hold0_nxt_s;
    logic [W-1:0]  dout0_r;
    logic [W-1:0]  dout0_nxt_s;
    logic [W-1:0]  dout1_r;
    logic [W-1:0]  dout1_nxt_s;
    logic          m_valid_r;
    logic          m_valid_nxt_s;
    logic          err_r;
    logic          err_nxt_s;
    logic          err_set_s;
    logic          cnt_inc_s;
    logic [CW-1:0] pair_cnt_r;
    logic          in_xfer_s;
    logic          out_xfer_s;

    // Upstream handshake: a pending pair only blocks input when the consumer is not taking it now.
    always_comb begin
        s_ready    = ce && ((state_r != ST_FULL) || m_ready);
        in_xfer_s  = s_valid && s_ready;
        out_xfer_s = m_valid_r && m_ready && ce;
    end

    // Pairing FSM: next state, hold register, output pair and event strobes.
    always_comb begin
        state_nxt_s   = state_r;
        hold0_nxt_s   = hold0_r;
        dout0_nxt_s   = dout0_r;
        dout1_nxt_s   = dout1_r;
        m_valid_nxt_s = m_valid_r;
        err_set_s     = 1'b0;
        cnt_inc_s     = 1'b0;
        if (ce) begin
            case (state_r)
                ST_WAIT0: begin
                    if (in_xfer_s && !s_lane) begin
                        hold0_nxt_s = s_data;
                        state_nxt_s = ST_WAIT1;
                    end else if (in_xfer_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT0;
                    end
                end
                ST_WAIT1: begin
                    if (in_xfer_s && s_lane) begin
                        dout0_nxt_s   = hold0_r;
                        dout1_nxt_s   = s_data;
                        m_valid_nxt_s = 1'b1;
                        state_nxt_s   = ST_FULL;
                    end else if (in_xfer_s) begin
                        // A second lane-0 beat resynchronises on the newest value.
                        hold0_nxt_s = s_data;
                        err_set_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT1;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        m_valid_nxt_s = 1'b0;
                        cnt_inc_s     = 1'b1;
                        if (in_xfer_s && !s_lane) begin
                            hold0_nxt_s = s_data;
                            state_nxt_s = ST_WAIT1;
                        end else if (in_xfer_s) begin
                            err_set_s   = 1'b1;
                            state_nxt_s = ST_WAIT0;
                        end else begin
                            state_nxt_s = ST_WAIT0;
                        end
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s   = ST_WAIT0;
                    m_valid_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Sticky error flag: a fresh error outranks a clear request in the same cycle.
    always_comb begin
        err_nxt_s = err_r;
        if (!ce) begin
            err_nxt_s = err_r;
        end else if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (clr_err) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State and output registers; reset discards any partial or undelivered pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_WAIT0;
            hold0_r    <= {W{1'b0}};
            dout0_r    <= {W{1'b0}};
            dout1_r    <= {W{1'b0}};
            m_valid_r  <= 1'b0;
            err_r      <= 1'b0;
            pair_cnt_r <= {CW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            hold0_r   <= hold0_nxt_s;
            dout0_r   <= dout0_nxt_s;
            dout1_r   <= dout1_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            err_r     <= err_nxt_s;
            if (cnt_inc_s) begin
                pair_cnt_r <= pair_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                pair_cnt_r <= pair_cnt_r;
            end
        end
    end

    assign m_valid  = m_valid_r;
    assign dout0    = dout0_r;
    assign dout1    = dout1_r;
    assign err_seq  = err_r;
    assign pair_cnt = pair_cnt_r;

endmodule

// File: tb/tb_dual_lane_deinterleaver.sv
// Bench for dual_lane_deinterleaver: directed scenarios plus random traffic, all checked
// every cycle against a pending-value/output-slot model of the pairing rules.
module tb_dual_lane_deinterleaver;
    localparam int W  = 17;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_lane = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [W-1:0]  dout0;
    logic [W-1:0]  dout1;
    logic          err_seq;
    logic          clr_err = 1'b0;
    logic [CW-1:0] pair_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a pending lane-0 value (or none), an output slot (or empty), the flag and a count.
    logic          md_have;
    logic [W-1:0]  md_hold;
    logic          md_ov;
    logic [W-1:0]  md_d0;
    logic [W-1:0]  md_d1;
    logic          md_err;
    int            md_cnt;

    dual_lane_deinterleaver #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_lane(s_lane), .m_valid(m_valid), .m_ready(m_ready),
        .dout0(dout0), .dout1(dout1), .err_seq(err_seq), .clr_err(clr_err),
        .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        return 32'(md_cnt % (1 << CW));
    endfunction

    task automatic model_reset();
        md_have = 1'b0; md_hold = '0; md_ov = 1'b0;
        md_d0 = '0; md_d1 = '0; md_err = 1'b0; md_cnt = 0;
    endtask

    task automatic model_edge();
        logic rdy, inx, outx, e;
        if (!rst) begin
            model_reset();
        end else if (ce) begin
            rdy  = !md_ov || m_ready;
            inx  = s_valid && rdy;
            outx = md_ov && m_ready;
            e    = 1'b0;
            if (outx) begin
                md_ov = 1'b0;
                md_cnt++;
            end
            if (inx && !s_lane) begin
                if (md_have) e = 1'b1;
                md_hold = s_data;
                md_have = 1'b1;
            end else if (inx && s_lane) begin
                if (md_have) begin
                    md_d0 = md_hold; md_d1 = s_data; md_ov = 1'b1; md_have = 1'b0;
                end else begin
                    e = 1'b1;
                end
            end
            if (e) md_err = 1'b1;
            else if (clr_err) md_err = 1'b0;
        end
    endtask

    // Compare process: registered outputs at the falling edge, s_ready once inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            check("m_valid", 32'(m_valid), 32'(md_ov));
            check("dout0", 32'(dout0), 32'(md_d0));
            check("dout1", 32'(dout1), 32'(md_d1));
            check("err_seq", 32'(err_seq), 32'(md_err));
            check("pair_cnt", 32'(pair_cnt), exp_cnt());
            #3;
            check("s_ready", 32'(s_ready), 32'(ce && (!md_ov || m_ready)));
        end
    end

    task automatic set_in(input logic v, input logic ln, input logic [W-1:0] d,
                          input logic mr, input logic c, input logic clr);
        s_valid = v; s_lane = ln; s_data = d; m_ready = mr; ce = c; clr_err = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    int base;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_dout0", 32'(dout0), 32'd0);
        check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
        check("rst_err", 32'(err_seq), 32'd0);
        rst = 1'b1;

        // 1: single pair (5, -3)
        set_in(1'b1, 1'b0, 17'd5, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b1, -17'sd3, 1'b1, 1'b1, 1'b0); tick();
        check("t1_m_valid", 32'(m_valid), 32'd1);
        check("t1_dout0", 32'(dout0), 32'd5);
        check("t1_dout1", 32'(dout1), 32'h1FFFD);
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0); tick();
        check("t1_pair_cnt", 32'(pair_cnt), 32'd1);

        // 2: streaming 1..8
        base = int'(pair_cnt);
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, ((i % 2) == 0), 17'(i), 1'b1, 1'b1, 1'b0);
            #1;
            check("t2_s_ready", 32'(s_ready), 32'd1);
            tick();
            if ((i % 2) == 0) begin
                check("t2_dout0", 32'(dout0), 32'(i - 1));
                check("t2_dout1", 32'(dout1), 32'(i));
            end
        end
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0); tick();
        check("t2_pairs", 32'((int'(pair_cnt) - base) & 15), 32'd4);
        check("t2_err", 32'(err_seq), 32'd0);

        // 3: backpressure
        set_in(1'b1, 1'b0, 17'd10, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b1, 17'd20, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 17'd30, 1'b0, 1'b1, 1'b0);
            #1;
            check("t3_s_ready_low", 32'(s_ready), 32'd0);
            tick();
            check("t3_hold_d0", 32'(dout0), 32'd10);
            check("t3_hold_d1", 32'(dout1), 32'd20);
            check("t3_hold_v", 32'(m_valid), 32'd1);
        end
        set_in(1'b1, 1'b0, 17'd30, 1'b1, 1'b1, 1'b0);
        #1;
        check("t3_s_ready_high", 32'(s_ready), 32'd1);
        tick();
        check("t3_accepted", 32'(m_valid), 32'd0);
        set_in(1'b1, 1'b1, 17'd40, 1'b1, 1'b1, 1'b0); tick();
        check("t3_d0_30", 32'(dout0), 32'd30);
        check("t3_d1_40", 32'(dout1), 32'd40);
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0); tick();

        // 4: sequence errors
        set_in(1'b1, 1'b1, 17'd7, 1'b1, 1'b1, 1'b0); tick();
        check("t4_err_set", 32'(err_seq), 32'd1);
        check("t4_dropped", 32'(m_valid), 32'd0);
        set_in(1'b1, 1'b0, 17'd1, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b0, 17'd2, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b1, 17'd3, 1'b1, 1'b1, 1'b0); tick();
        check("t4_d0_2", 32'(dout0), 32'd2);
        check("t4_d1_3", 32'(dout1), 32'd3);
        check("t4_err_sticky", 32'(err_seq), 32'd1);
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b1); tick();
        check("t4_err_clr", 32'(err_seq), 32'd0);
        set_in(1'b1, 1'b1, 17'd9, 1'b1, 1'b1, 1'b1); tick();
        check("t4_err_wins", 32'(err_seq), 32'd1);
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b1); tick();

        // 5: ce gating mid-pair and while a pair is pending
        set_in(1'b1, 1'b0, 17'd50, 1'b1, 1'b1, 1'b0); tick();
        base = int'(pair_cnt);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 17'd60, 1'b1, 1'b0, 1'b0);
            #1;
            check("t5_s_ready", 32'(s_ready), 32'd0);
            tick();
            check("t5_no_pair", 32'(m_valid), 32'd0);
            check("t5_cnt_frozen", 32'(pair_cnt), 32'(base));
        end
        set_in(1'b1, 1'b1, 17'd60, 1'b1, 1'b1, 1'b0); tick();
        check("t5_d0_50", 32'(dout0), 32'd50);
        check("t5_d1_60", 32'(dout1), 32'd60);
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b0, 1'b0); tick();
            check("t5_full_frozen", 32'(m_valid), 32'd1);
        end
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0); tick();

        // 6: asynchronous reset in WAIT1 and in FULL
        set_in(1'b1, 1'b0, 17'd70, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b0);
        #1; rst = 1'b0; model_reset(); #1;
        check("t6a_cnt", 32'(pair_cnt), 32'd0);
        check("t6a_m_valid", 32'(m_valid), 32'd0);
        tick();
        rst = 1'b1;
        set_in(1'b1, 1'b0, 17'd80, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b1, 17'd90, 1'b0, 1'b1, 1'b0); tick();
        check("t6b_full", 32'(m_valid), 32'd1);
        set_in(1'b0, 1'b0, 17'd0, 1'b0, 1'b1, 1'b0);
        #1; rst = 1'b0; model_reset(); #1;
        check("t6b_m_valid", 32'(m_valid), 32'd0);
        check("t6b_dout0", 32'(dout0), 32'd0);
        check("t6b_dout1", 32'(dout1), 32'd0);
        check("t6b_cnt", 32'(pair_cnt), 32'd0);
        tick();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 17'd91, 1'b1, 1'b1, 1'b0); tick();
        check("t6_err_after", 32'(err_seq), 32'd1);

        // Random traffic; the narrow counter wraps many times here.
        for (int i = 0; i < 4000; i++) begin
            logic ln;
            ln = ($urandom_range(99) < 85) ? md_have : 1'($urandom_range(1));
            set_in(($urandom_range(99) < 75), ln, 17'($urandom),
                   ($urandom_range(99) < 70), ($urandom_range(99) < 90),
                   ($urandom_range(99) < 5));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dual_lane_deinterleaver.md
Name: dual_lane_deinterleaver

Overview:
- Receive end of the time-multiplexed dual-MAC result path.
- A shared DSP emits lane-0 and lane-1 results serially on one stream, tagged by lane. This block re-pairs them into one parallel (dout0, dout1) word per pair.
- Sits between the shared-DSP result port and the per-lane consumers.
- Adds valid/ready flow control, sequence checking and a pair counter.

Parameters:
- W, 17: width of each signed result (matches the 8x8+8 MAC result width).
- CW, 16: width of the delivered-pair counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low the whole block freezes.
- s_valid  in  1  input result valid.
- s_ready  out  1  block can accept an input result.
- s_data  in  W  signed result from the shared MAC.
- s_lane  in  1  lane tag of s_data (0 = lane 0, 1 = lane 1).
- m_valid  out  1  dout0/dout1 hold a complete pair.
- m_ready  in  1  consumer accepts the pair.
- dout0  out  W  signed lane-0 result.
- dout1  out  W  signed lane-1 result.
- err_seq  out  1  sticky lane-sequence error flag.
- clr_err  in  1  clears err_seq.
- pair_cnt  out  CW  count of delivered pairs, wraps modulo 2^CW.

Behaviour:
- Reset (rst=0, asynchronous): state=WAIT0, m_valid=0, dout0=0, dout1=0, err_seq=0, pair_cnt=0, internal lane-0 hold register=0. s_ready follows its combinational rule below.
- In-transfer: s_valid && s_ready. Out-transfer: m_valid && m_ready && ce.
- s_ready = ce && (state!=FULL || m_ready). This is combinational; no combinational path from s_valid to s_ready.
- ce=0: no state, register, counter or flag changes. s_ready=0. m_valid and the outputs hold their values. m_ready is ignored.
- FSM states and transitions (evaluated only when ce=1):
  - WAIT0, in-transfer with lane 0: capture s_data into hold0; go to WAIT1.
  - WAIT0, in-transfer with lane 1: drop the data; set err_seq; stay in WAIT0.
  - WAIT1, in-transfer with lane 1: dout0<=hold0, dout1<=s_data, m_valid<=1; go to FULL.
  - WAIT1, in-transfer with lane 0: overwrite hold0 (resync); set err_seq; stay in WAIT1.
  - FULL, no out-transfer: hold dout0, dout1 and m_valid stable; s_ready=0.
  - FULL, out-transfer: m_valid<=0 and pair_cnt<=pair_cnt+1.
    - Same cycle with lane-0 in-transfer: capture hold0; go to WAIT1.
    - Same cycle with lane-1 in-transfer: drop the data; set err_seq; go to WAIT0.
    - No in-transfer: go to WAIT0.
- Latency: lane-1 accepted at edge t gives m_valid=1 with both values after edge t; visible in cycle t+1.
- Throughput: with m_ready held at 1, one pair per 2 cycles with no bubbles.
- Data is passed through bit-exact; no arithmetic and no sign change. dout values change only on the WAIT1 to FULL transition.
- pair_cnt wraps from 2^CW-1 to 0 with no flag.
- err_seq is sticky. clr_err=1 clears it on the next edge when ce=1. A new error in the same cycle as clr_err wins: err_seq stays 1.
- Reset asserted mid-pair discards hold0 and any pending FULL pair; pair_cnt does not count the lost pair.

Test Plan:
1. Release reset with ce=1 and m_ready=1. Send (lane0, 5), then (lane1, -3) on consecutive cycles. Required: one cycle later m_valid=1, dout0=5, dout1=-3 (17'h1FFFD); pair_cnt=1 after the accept.
2. Streaming: 8 alternating beats with m_ready=1, values 1..8. Required:
   - pairs (1,2), (3,4), (5,6), (7,8);
   - s_ready never drops;
   - pair_cnt=4;
   - err_seq=0.
3. Backpressure:
   - complete pair (10, 20) with m_ready=0 for 3 cycles;
   - required: s_ready=0 and outputs stable for those 3 cycles;
   - raise m_ready with lane-0 value 30 offered: pair accepted and 30 captured in the same cycle, then state WAIT1.
4. Sequence errors:
   - in WAIT0 send lane1=7: dropped, err_seq=1;
   - then lane0=1, lane0=2, lane1=3: pair (2,3), err_seq stays 1;
   - pulse clr_err: err_seq=0.
5. ce gating: hold ce=0 for 4 cycles in the middle of a pair, with s_valid=1. Required: s_ready=0, no capture, pair_cnt unchanged. After ce returns to 1 the pair completes correctly.
6. Reset mid-operation:
   - assert rst=0 asynchronously (between edges) in WAIT1 and in FULL;
   - required: outputs go to 0 immediately, m_valid=0, pair_cnt=0;
   - next lane-1 beat after release sets err_seq=1.
